// File: rtl/rv_bus_mem_slave_if.sv
// Word-wide request/response bus between a requester (cache or load/store path)
// and the memory slave; the i_/o_ prefixes are from the slave's point of view.
`timescale 1ns/1ps
interface rv_bus_mem_slave_if;
  logic [31:0] i_addr;
  logic        i_read;
  logic        i_write;
  logic [3:0]  i_write_sel;
  logic [31:0] i_write_data;
  logic [31:0] o_data;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_addr, i_read, i_write, i_write_sel, i_write_data,
    input  o_data, o_ack, o_busy
  );

  modport slave (
    input  i_addr, i_read, i_write, i_write_sel, i_write_data,
    output o_data, o_ack, o_busy
  );
endinterface

// File: rtl/rv_bus_mem_slave.sv
// Bus memory slave: decodes its window on the top address bits, latches a request,
// waits WAIT_STATES cycles, performs the word access and pulses o_ack for one cycle.
`timescale 1ns/1ps
`ifndef SLAVE_SEL_WIDTH
`define SLAVE_SEL_WIDTH 4
`endif

module rv_bus_mem_slave #(
  parameter int                          MEM_ADDR_BIT = 10,
  parameter int                          WAIT_STATES  = 2,
  parameter logic [`SLAVE_SEL_WIDTH-1:0] ADDR_HI      = {`SLAVE_SEL_WIDTH{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  rv_bus_mem_slave_if.slave  bus
);

  localparam int         SSW     = `SLAVE_SEL_WIDTH;
  localparam int         DEPTH   = 1 << MEM_ADDR_BIT;
  localparam logic       WS_ZERO = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD = WS_ZERO ? 4'd0 : 4'(WAIT_STATES - 1);

  if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait
    $fatal(1, "rv_bus_mem_slave: WAIT_STATES must be 0..15");
  end
  if (MEM_ADDR_BIT > 30 - SSW) begin : g_bad_addr
    $fatal(1, "rv_bus_mem_slave: MEM_ADDR_BIT overlaps the slave select field");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                    state_r, state_s;
  logic [3:0]                cnt_r, cnt_s;
  logic [MEM_ADDR_BIT-1:0]   idx_r, idx_s;
  logic                      wr_r, wr_s;
  logic [3:0]                lanes_r, lanes_s;
  logic [31:0]               wdata_r, wdata_s;
  logic                      ack_r, busy_r;
  logic [31:0]               data_r;
  logic                      sel_s;
  logic                      enter_ack_s;
  logic                      unused_addr_s;
  logic [31:0]               mem_r [0:DEPTH-1];

  assign sel_s         = (bus.i_addr[31 -: SSW] == ADDR_HI) && (bus.i_read || bus.i_write);
  assign unused_addr_s = ^bus.i_addr;
  assign bus.o_ack     = ack_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_data    = data_r;

  // Next-state logic; the *_s request copies are also the access operands, so a
  // zero-wait transfer uses the live request and a delayed one uses the latched copy.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    wr_s    = wr_r;
    lanes_s = lanes_r;
    wdata_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_s) begin
          idx_s   = bus.i_addr[MEM_ADDR_BIT+1:2];
          wr_s    = bus.i_write;
          lanes_s = bus.i_write_sel;
          wdata_s = bus.i_write_data;
          if (WS_ZERO) begin
            state_s = ST_ACK;
          end else begin
            cnt_s   = WS_LOAD;
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_ACK;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          state_s = ST_WAIT;
        end
      end
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign enter_ack_s = (state_s == ST_ACK) && (state_r != ST_ACK);

  // State, latched request and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= {MEM_ADDR_BIT{1'b0}};
      wr_r    <= 1'b0;
      lanes_r <= 4'd0;
      wdata_r <= 32'd0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      wr_r    <= wr_s;
      lanes_r <= lanes_s;
      wdata_r <= wdata_s;
      ack_r   <= (state_s == ST_ACK);
      busy_r  <= (state_s == ST_WAIT);
      if (enter_ack_s && !wr_s) begin
        data_r <= mem_r[idx_s];
      end
    end
  end

  // Byte-lane writes into the word array; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (enter_ack_s && wr_s) begin
      for (int n = 0; n < 4; n++) begin
        if (lanes_s[n]) begin
          mem_r[idx_s][8*n +: 8] <= wdata_s[8*n +: 8];
        end
      end
    end
  end

endmodule
